// File: rtl/des_pkg.sv
// DES substitution tables and index helpers.
// Shared by des_sbox_layer and des_sbox_arbiter.
package des_pkg;

  localparam int DES_SBOX_IN_W  = 48;
  localparam int DES_SBOX_OUT_W = 32;
  localparam int DES_SBOX_IDX_W = 6;

  // Row r of S-box b at entry 4*b+r; column 0 in the top nibble.
  localparam logic [63:0] SBOX_ROW [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
    64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
    64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
    64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
    64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
    64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
    64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
    64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [DES_SBOX_IDX_W-1:0] sbox_idx(
    input logic [DES_SBOX_IN_W-1:0] d,
    input int unsigned              k
  );
    logic [DES_SBOX_IN_W-1:0] t;
    t = d << (6 * k);
    return t[47:42];
  endfunction

  function automatic logic [3:0] sbox_lu(
    input logic [2:0]                k,
    input logic [DES_SBOX_IDX_W-1:0] ix
  );
    logic [4:0]  a;
    logic [5:0]  sh;
    logic [63:0] row;
    a   = {k, ix[5], ix[0]};
    sh  = {~ix[4:1], 2'b00};
    row = SBOX_ROW[a];
    return row[sh +: 4];
  endfunction

endpackage

// File: rtl/des_sbox_layer.sv
// Combinational DES S1..S8 layer, 48b in -> 32b out.
// S1 consumes [47:42] and drives [31:28].
module des_sbox_layer
  import des_pkg::*;
(
  input  logic [DES_SBOX_IN_W-1:0]  i_din,
  output logic [DES_SBOX_OUT_W-1:0] o_dout
);

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    assign o_dout[4*(7-g) +: 4] =
      sbox_lu(3'(g), sbox_idx(i_din, g));
  end

endmodule

// File: rtl/des_sbox_arbiter.sv
// Round-robin share of one S-box layer, 2-stage pipe.
// DES_SBOX_ARB_PERF_EN adds per-requester grant counters.
module des_sbox_arbiter
  import des_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*48-1:0]     req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [31:0]               rsp_data
`ifdef DES_SBOX_ARB_PERF_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]  perf_grant_cnt
`endif
);

  logic [1:0]               r_rr_ptr;
  logic                     r_s1_valid;
  logic [DES_SBOX_IN_W-1:0] r_s1_data;
  logic [1:0]               r_s1_id;
  logic [NUM_REQ-1:0]       r_rsp_valid;
  logic [31:0]              r_rsp_data;

  logic [NUM_REQ-1:0]       w_grant;
  logic [1:0]               w_win;
  logic [DES_SBOX_IN_W-1:0] w_sel;
  logic                     w_found;
  int                       w_j;
  logic                     w_s2_free;
  logic                     w_s1_free;
  logic                     w_accept;
  logic [31:0]              w_sub;
  logic [NUM_REQ-1:0]       w_s1_oh;

  // Owner identity is carried by the one-hot rsp_valid itself.
  assign w_s2_free = !(|r_rsp_valid)
                   || |(r_rsp_valid & rsp_ready);
  assign w_s1_free = !r_s1_valid || w_s2_free;

  always_comb begin
    w_grant = '0;
    w_win   = r_rr_ptr;
    w_sel   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[w_j]) begin
        w_found    = 1'b1;
        w_grant[w_j] = 1'b1;
        w_win      = 2'(w_j);
        w_sel      = req_data[48*w_j +: 48];
      end
    end
  end

  assign req_ready = rst ? '0
                   : w_grant & {NUM_REQ{w_s1_free}};
  assign w_accept  = |req_ready;
  assign w_s1_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1}
                   << r_s1_id;

  des_sbox_layer u_layer (
    .i_din  (r_s1_data),
    .o_dout (w_sub)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= 2'(NUM_REQ - 1);
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_id     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_s2_free) begin
        r_rsp_valid <= r_s1_valid ? w_s1_oh : '0;
        if (r_s1_valid) r_rsp_data <= w_sub;
      end
      if (w_s1_free) r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= w_sel;
        r_s1_id   <= w_win;
        r_rr_ptr  <= w_win;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

`ifdef DES_SBOX_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else if (req_valid[i] && req_ready[i]
               && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
    assign perf_grant_cnt[CNT_W*i +: CNT_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_des_sbox_arbiter.sv
// Directed bench for des_sbox_arbiter, NUM_REQ=2.
// Perf-counter step runs only with DES_SBOX_ARB_PERF_EN.
module tb_des_sbox_arbiter;

  localparam int N  = 2;
  localparam int CW = 4;
  localparam logic [31:0] R0 = 32'hEFA72C4D;
  localparam logic [31:0] R1 = 32'hD9CE3DCB;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*48-1:0] req_data;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [31:0]   rsp_data;
`ifdef DES_SBOX_ARB_PERF_EN
  logic [N*CW-1:0] perf_grant_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_sbox_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
`ifdef DES_SBOX_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    req_data = {48'hFFFF_FFFF_FFFF, 48'h0};
    rst       = 1'b1;
    req_valid = 2'b11;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;

    // single request from req0
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("t1_mid_valid", 32'(rsp_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_data", rsp_data, R0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_drain", 32'(rsp_valid), 0);

    // single request from req1
    #1 req_valid = 2'b10;
    @(negedge clk);
    chk("t2_ready", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("t2_valid", 32'(rsp_valid), 32'h2);
    chk("t2_data", rsp_data, R1);
    @(posedge clk);

    // both requesting, full throughput from reset
    do_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t3_grant%0d", k),
          32'(req_ready), (k % 2 == 0) ? 1 : 2);
      if (k < 2) begin
        chk($sformatf("t3_fill%0d", k),
            32'(rsp_valid), 0);
      end else begin
        chk($sformatf("t3_rv%0d", k), 32'(rsp_valid),
            (k % 2 == 0) ? 1 : 2);
        chk($sformatf("t3_rd%0d", k), rsp_data,
            (k % 2 == 0) ? R0 : R1);
      end
      @(posedge clk);
    end

    // owner (req0) stalls; req1's ready must be ignored
    #1 rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t4_rv%0d", k), 32'(rsp_valid), 1);
      chk($sformatf("t4_rd%0d", k), rsp_data, R0);
      chk($sformatf("t4_rr%0d", k), 32'(req_ready), 0);
      @(posedge clk);
    end
    #1 rsp_ready = 2'b11;
    @(negedge clk);
    chk("t4_rel_rv", 32'(rsp_valid), 1);
    chk("t4_rel_rr", 32'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    chk("t4_nx1_rv", 32'(rsp_valid), 2);
    chk("t4_nx1_rd", rsp_data, R1);
    chk("t4_nx1_rr", 32'(req_ready), 2);
    @(posedge clk);
    @(negedge clk);
    chk("t4_nx2_rv", 32'(rsp_valid), 1);
    chk("t4_nx2_rd", rsp_data, R0);
    @(posedge clk);

    // reset with both stages full
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_rr_in_rst", 32'(req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_rv", 32'(rsp_valid), 0);
    chk("t5_rr", 32'(req_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_first_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("t5_no_stale", 32'(rsp_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_rsp_rv", 32'(rsp_valid), 1);
    chk("t5_rsp_rd", rsp_data, R0);
    @(posedge clk);

`ifdef DES_SBOX_ARB_PERF_EN
    do_reset();
    @(negedge clk);
    chk("t6_cnt_rst", 32'(perf_grant_cnt), 0);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_cnt3", 32'(perf_grant_cnt), 32'h03);
    repeat (17) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("t6_cnt_sat", 32'(perf_grant_cnt), 32'h0F);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
